// File: rtl/mips_mmio_pkg.sv
// Shared address map, status-bit layout and decode types for the data-bus
// responder and its TX FIFO.
package mips_mmio_pkg;

  localparam logic [31:0] LED_ADDR       = 32'h0000_FF00;
  localparam logic [31:0] CYCLES_ADDR    = 32'h0000_FF04;
  localparam logic [31:0] TX_DATA_ADDR   = 32'h0000_FF08;
  localparam logic [31:0] TX_STATUS_ADDR = 32'h0000_FF0C;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;
  localparam int ST_DROP      = 8;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_LED,
    RG_CYC,
    RG_TXD,
    RG_TXS
  } region_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide TX FIFO. Head is zero when empty; a push while full is accepted
// only if a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // when full, the slot under wr_ptr is the head being popped this edge
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus LED,
// cycle counter and TX FIFO registers, with combinational loads.
module data_bus_responder
  import mips_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        mem_we,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bus_req_t      req;
  region_e       region;
  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycles;
  logic          drop;
  logic          push, pop, empty, full;
  logic [CW-1:0] count;
  logic [31:0]   status;

  assign req = '{addr: addr, we: mem_we, wdata: write_data};

  // RAM decode takes priority should a large RAM ever reach the MMIO window
  always_comb begin
    region = RG_NONE;
    if (req.addr[31:AW+2] == '0) region = RG_RAM;
    else begin
      case (req.addr)
        LED_ADDR:       region = RG_LED;
        CYCLES_ADDR:    region = RG_CYC;
        TX_DATA_ADDR:   region = RG_TXD;
        TX_STATUS_ADDR: region = RG_TXS;
        default:        region = RG_NONE;
      endcase
    end
  end

  assign pop      = tx_valid & tx_ready;
  assign push     = req.we & (region == RG_TXD);
  assign tx_valid = ~empty;

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req.wdata[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // RAM is not reset, but a store landing while reset is held is dropped
  always_ff @(posedge clk) begin
    if (rst && req.we && region == RG_RAM) ram[req.addr[AW+1:2]] <= req.wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led    <= '0;
      cycles <= '0;
      drop   <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (req.we && region == RG_LED) led <= req.wdata[7:0];
      if (req.we && region == RG_TXS)  drop <= 1'b0;
      else if (push && full && !pop)   drop <= 1'b1;
    end
  end

  always_comb begin
    status                                = '0;
    status[ST_EMPTY]                      = empty;
    status[ST_FULL]                       = full;
    status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(count);
    status[ST_DROP]                       = drop;
  end

  always_comb begin
    read_data = '0;
    case (region)
      RG_RAM:  read_data = ram[req.addr[AW+1:2]];
      RG_LED:  read_data = {24'h0, led};
      RG_CYC:  read_data = cycles;
      RG_TXS:  read_data = status;
      default: read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder; TX bytes are checked against a
// scoreboard queue filled at each store to TX_DATA.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        mem_we;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  localparam logic [31:0] LED_A = 32'h0000_FF00;
  localparam logic [31:0] CYC_A = 32'h0000_FF04;
  localparam logic [31:0] TXD_A = 32'h0000_FF08;
  localparam logic [31:0] TXS_A = 32'h0000_FF0C;

  data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .mem_we     (mem_we),
    .write_data (write_data),
    .read_data  (read_data),
    .led        (led),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; write_data = d; mem_we = 1'b1;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; mem_we = 1'b0;
    #1;
    chk(tag, read_data, exp);
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    chk({tag, "_valid_low"}, {31'h0, tx_valid}, 32'h0);
    chk({tag, "_sb_empty"}, sb.size(), 32'h0);
  endtask

  // every byte the consumer takes must be the oldest one pushed
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL tx_pop_extra observed=%h expected=none", tx_data);
      end
      if (sb.size() > 0) chk("tx_pop", {24'h0, tx_data}, {24'h0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = '0; mem_we = 1'b0; write_data = '0; tx_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst = 1'b1;
    load_chk("cyc0", CYC_A, 32'd0);
    load_chk("status_rst", TXS_A, 32'h0000_0001);
    @(posedge clk); #1;
    load_chk("cyc1", CYC_A, 32'd1);
    @(posedge clk); #1;
    load_chk("cyc2", CYC_A, 32'd2);

    // RAM
    store(32'h0000_0000, 32'hCAFE_0001);
    store(32'h0000_0014, 32'h1234_5678);
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    load_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    load_chk("ram_14", 32'h0000_0014, 32'h1234_5678);

    // LED and unmapped
    store(LED_A, 32'h0000_01A5);
    chk("led_out", {24'h0, led}, 32'h0000_00A5);
    load_chk("led_rd", LED_A, 32'h0000_00A5);
    store(32'h0000_8000, 32'hFFFF_FFFF);
    load_chk("unmapped_rd", 32'h0000_8000, 32'h0);
    load_chk("ram_0_alias", 32'h0000_0000, 32'hCAFE_0001);
    chk("led_kept", {24'h0, led}, 32'h0000_00A5);
    load_chk("txd_rd", TXD_A, 32'h0);

    // fill, overflow, drain
    addr = TXD_A; write_data = 32'h11; mem_we = 1'b1;
    #1;
    chk("no_bypass", {31'h0, tx_valid}, 32'h0);
    sb.push_back(8'h11);
    @(posedge clk); #1;
    mem_we = 1'b0;
    chk("valid_after_push", {31'h0, tx_valid}, 32'h1);
    store(TXD_A, 32'h22); sb.push_back(8'h22);
    store(TXD_A, 32'h33); sb.push_back(8'h33);
    store(TXD_A, 32'h44); sb.push_back(8'h44);
    store(TXD_A, 32'h55);
    load_chk("status_full_drop", TXS_A, 32'h0000_0142);
    chk("head_11", {24'h0, tx_data}, 32'h11);
    drain("drain1");
    load_chk("drop_sticky", TXS_A, 32'h0000_0101);
    store(TXS_A, 32'h0);
    load_chk("drop_clear", TXS_A, 32'h0000_0001);

    // push while full with simultaneous pop
    store(TXD_A, 32'hA1); sb.push_back(8'hA1);
    store(TXD_A, 32'hA2); sb.push_back(8'hA2);
    store(TXD_A, 32'hA3); sb.push_back(8'hA3);
    store(TXD_A, 32'hA4); sb.push_back(8'hA4);
    addr = TXD_A; write_data = 32'h66; mem_we = 1'b1; tx_ready = 1'b1;
    sb.push_back(8'h66);
    @(posedge clk); #1;
    mem_we = 1'b0; tx_ready = 1'b0;
    load_chk("status_push_pop", TXS_A, 32'h0000_0042);
    chk("head_a2", {24'h0, tx_data}, 32'hA2);
    drain("drain2");

    // asynchronous reset mid-cycle
    store(LED_A, 32'h5A);
    store(TXD_A, 32'h77); sb.push_back(8'h77);
    store(TXD_A, 32'h88); sb.push_back(8'h88);
    chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_led", {24'h0, led}, 32'h0);
    chk("async_tx_data", {24'h0, tx_data}, 32'h0);
    load_chk("async_status", TXS_A, 32'h0000_0001);
    load_chk("async_cyc", CYC_A, 32'h0);
    sb.delete();
    addr = 32'h0000_0010; write_data = 32'h0; mem_we = 1'b1;
    @(posedge clk); #1;
    mem_we = 1'b0;
    rst = 1'b1;
    load_chk("ram_10_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    load_chk("ram_14_kept", 32'h0000_0014, 32'h1234_5678);
    load_chk("ram_0_kept", 32'h0000_0000, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder side of the single-cycle core's data-memory port. It takes the core's address, write-enable and write data and returns read data in the same cycle. It holds a word-addressed data RAM and a small memory-mapped I/O region: an LED register, a free-running cycle counter, and a byte-wide transmit FIFO drained by an external valid/ready consumer. It sits beside the core at the top level, wired to the core's ALU-result address output and memory-write outputs.

## Interface
Parameters:
- RAM_WORDS, 64: data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- addr, in, 32: byte address from the core's ALU result.
- mem_we, in, 1: store strobe; write committed at the next rising edge.
- write_data, in, 32: store data.
- read_data, out, 32: load data, combinational from addr.
- led, out, 8: LED register contents.
- tx_data, out, 8: FIFO head byte.
- tx_valid, out, 1: FIFO non-empty.
- tx_ready, in, 1: consumer accepts head when tx_valid & tx_ready.

## Operation
- addr[1:0] is ignored; all accesses are full-word.
- Memory map:
  - 0x0000_0000 to RAM_WORDS*4-1: RAM, read/write, word index addr[log2(RAM_WORDS)+1:2].
  - 0xFF00 LED: read/write; stores write_data[7:0]; reads zero-extended.
  - 0xFF04 CYCLES: read-only.
  - 0xFF08 TX_DATA: write-only; a store pushes write_data[7:0]; reads return 0.
  - 0xFF0C TX_STATUS: read-only fields; a store of any value clears DROP.
  - Full addr[31:0] is compared for MMIO.
- Unmapped addresses: reads return 0; writes are ignored with no side effects.
- CYCLES: 32-bit counter, +1 every clock, wraps 0xFFFF_FFFF→0. A read returns the current registered value.
- TX_STATUS fields:
  - bit0 EMPTY.
  - bit1 FULL.
  - bits[7:4] COUNT, zero-extended.
  - bit8 DROP, sticky; set by a push while full when no pop occurs that cycle.
  - All other bits 0.
- FIFO behaviour:
  - A pop occurs when tx_valid & tx_ready.
  - Push while full with a simultaneous pop: both occur, count unchanged, the new byte is kept, DROP is not set.
  - Push while empty: the byte is not visible until the next cycle. No bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Stores to RAM update only the addressed word.

## Timing
- Reset values:
  - led=0, CYCLES=0.
  - FIFO empty, so tx_valid=0 and tx_data=0.
  - DROP=0.
  - read_data follows addr (RAM reads undefined until written; MMIO reads reflect reset values).
  - RAM contents are not reset.
- Load latency: 0 cycles (combinational). Store latency: effective at the rising edge where mem_we=1; the value is visible to a read in the following cycle.
- tx_valid rises 1 cycle after the first push into an empty FIFO. tx_data is stable while tx_valid & !tx_ready.
- Asserting rst mid-operation immediately empties the FIFO and clears led, CYCLES and DROP. Any in-flight store is lost. RAM retains its contents.
- No combinational path from tx_ready to read_data, or from addr to tx_valid.

## Structure
- Package mips_mmio_pkg holds:
  - Address constants LED_ADDR, CYCLES_ADDR, TX_DATA_ADDR, TX_STATUS_ADDR.
  - TX_STATUS bit-position constants.
- Sub-module tx_fifo, parameterised by FIFO_DEPTH:
  - Ports: push, push_data, pop, head, empty, full, count.
- The top level contains the address decode, read mux, RAM array, LED/CYCLES/DROP registers and the tx_fifo instance.

## Test plan
- Reset with rst=0 for 2 cycles, then release → led=0, tx_valid=0; TX_STATUS read = 0x0000_0001; CYCLES read increments by 1 per cycle from 0.
- Store 0xDEAD_BEEF to 0x10, then load 0x10 and 0x13 → both return 0xDEAD_BEEF; 0x14 is unchanged.
- Store 0x1A5 to 0xFF00 → led=0xA5 next cycle; a load returns 0x0000_00A5. A store to 0x8000 is ignored; a load from 0x8000 returns 0.
- With tx_ready=0, push 0x11,0x22,0x33,0x44, then 0x55:
  - Expect FULL=1, COUNT=4, DROP=1, head=0x11.
  - Raise tx_ready → pops 0x11,0x22,0x33,0x44 in order, then tx_valid=0.
  - Store to 0xFF0C → DROP=0.
- With the FIFO full and tx_ready=1, push 0x66 in the same cycle → DROP stays 0, COUNT stays 4, 0x66 emerges last.
- Pulse rst low asynchronously mid-cycle with 2 bytes queued → tx_valid and led drop to 0 immediately; previously stored RAM words read back unchanged.
